// File: rtl/vga_mem_arb_pkg.sv
// Shared types for the VGA memory arbiter.
// Grant encoding and default starvation bound.
package vga_mem_arb_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int HOST_MAX_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_DISP,
    GNT_WBUF,
    GNT_HOST_RD
  } grant_e;

endpackage

// File: rtl/vga_mem_wbuf.sv
// Single-entry host write buffer.
// Load wins over drain so a drain and refill share one cycle.
module vga_mem_wbuf
  import vga_mem_arb_pkg::*;
(
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Occupancy flag; a buffered write is dropped on reset.
  always_ff @(posedge clk_sys or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  // Payload only matters while valid, so it needs no reset.
  always_ff @(posedge clk_sys) begin
    if (load) begin
      addr <= load_addr;
      data <= load_data;
    end
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Arbitrates host and display access to VGA memory.
// Display has priority until the host side has waited too long.
module vga_mem_arbiter
  import vga_mem_arb_pkg::*;
#(
  parameter int HOST_MAX_WAIT = HOST_MAX_WAIT_DEF
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic [ADDR_W-1:0] host_address,
  input  logic              host_read,
  input  logic              host_write,
  input  logic [DATA_W-1:0] host_writedata,
  output logic [DATA_W-1:0] host_readdata,
  output logic              host_readdatavalid,
  output logic              host_waitrequest,
  input  logic [ADDR_W-1:0] disp_address,
  input  logic              disp_read,
  output logic [DATA_W-1:0] disp_readdata,
  output logic              disp_readdatavalid,
  output logic              disp_waitrequest,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam logic [2:0] MAX_W = 3'(HOST_MAX_WAIT);

  grant_e            grant;
  grant_e            owner;
  logic [2:0]        starve_cnt;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_accept;
  logic              host_rd_req;
  logic              host_pending;
  logic              host_gnt;
  logic              starved;
  logic [DATA_W-1:0] host_hold;
  logic [DATA_W-1:0] disp_hold;

  assign host_rd_req  = host_read & ~host_write;
  assign host_pending = wb_valid | host_rd_req;
  assign starved      = host_pending & (starve_cnt == MAX_W);
  assign host_gnt     = (grant == GNT_WBUF) | (grant == GNT_HOST_RD);
  assign wb_accept    = rst & host_write &
                        (~wb_valid | (grant == GNT_WBUF));

  vga_mem_wbuf u_wbuf (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .load      (wb_accept),
    .load_addr (host_address),
    .load_data (host_writedata),
    .drain     (grant == GNT_WBUF),
    .valid     (wb_valid),
    .addr      (wb_addr),
    .data      (wb_data)
  );

  // Per-cycle grant: starved host, display, drain, host read.
  always_comb begin
    grant = GNT_NONE;
    if (!rst) begin
      grant = GNT_NONE;
    end else if (starved) begin
      grant = wb_valid ? GNT_WBUF : GNT_HOST_RD;
    end else if (disp_read) begin
      grant = GNT_DISP;
    end else if (wb_valid) begin
      grant = GNT_WBUF;
    end else if (host_rd_req) begin
      grant = GNT_HOST_RD;
    end
  end

  // Memory port follows the grant combinationally.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = wb_data;
    unique case (grant)
      GNT_DISP: begin
        mem_read    = 1'b1;
        mem_address = disp_address;
      end
      GNT_WBUF: begin
        mem_write   = 1'b1;
        mem_address = wb_addr;
      end
      GNT_HOST_RD: begin
        mem_read    = 1'b1;
        mem_address = host_address;
      end
      default: ;
    endcase
  end

  // Waitrequests; an idle host port reports busy.
  always_comb begin
    host_waitrequest = 1'b1;
    disp_waitrequest = (grant != GNT_DISP);
    if (rst) begin
      if (host_write) begin
        host_waitrequest = ~wb_accept;
      end else if (host_read) begin
        host_waitrequest = (grant != GNT_HOST_RD);
      end
    end
  end

  // Count cycles the host side is pending but bypassed.
  always_ff @(posedge clk_sys or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!host_pending || host_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != MAX_W) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  // Remember who owns the read returning next cycle.
  always_ff @(posedge clk_sys or negedge rst) begin
    if (!rst) begin
      owner <= GNT_NONE;
    end else if (grant == GNT_DISP || grant == GNT_HOST_RD) begin
      owner <= grant;
    end else begin
      owner <= GNT_NONE;
    end
  end

  // Hold last returned byte per port between reads.
  always_ff @(posedge clk_sys) begin
    if (host_readdatavalid) host_hold <= mem_readdata;
    if (disp_readdatavalid) disp_hold <= mem_readdata;
  end

  assign host_readdatavalid = (owner == GNT_HOST_RD);
  assign disp_readdatavalid = (owner == GNT_DISP);
  assign host_readdata = host_readdatavalid ? mem_readdata : host_hold;
  assign disp_readdata = disp_readdatavalid ? mem_readdata : disp_hold;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: directed table, corner
// sequences and random traffic against a queue model.
module tb_vga_mem_arbiter;

  localparam int MAXW = 4;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b0;
  logic [16:0] host_address = '0;
  logic        host_read = 1'b0;
  logic        host_write = 1'b0;
  logic [7:0]  host_writedata = '0;
  logic [7:0]  host_readdata;
  logic        host_readdatavalid;
  logic        host_waitrequest;
  logic [16:0] disp_address = '0;
  logic        disp_read = 1'b0;
  logic [7:0]  disp_readdata;
  logic        disp_readdatavalid;
  logic        disp_waitrequest;
  logic [16:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_writedata;
  logic [7:0]  mem_readdata = '0;

  always #5 clk_sys = ~clk_sys;

  vga_mem_arbiter #(.HOST_MAX_WAIT(MAXW)) dut (
    .clk_sys            (clk_sys),
    .rst                (rst),
    .host_address       (host_address),
    .host_read          (host_read),
    .host_write         (host_write),
    .host_writedata     (host_writedata),
    .host_readdata      (host_readdata),
    .host_readdatavalid (host_readdatavalid),
    .host_waitrequest   (host_waitrequest),
    .disp_address       (disp_address),
    .disp_read          (disp_read),
    .disp_readdata      (disp_readdata),
    .disp_readdatavalid (disp_readdatavalid),
    .disp_waitrequest   (disp_waitrequest),
    .mem_address        (mem_address),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_writedata      (mem_writedata),
    .mem_readdata       (mem_readdata)
  );

  function automatic logic [7:0] pat(input logic [16:0] a);
    return a[7:0] ^ {1'b0, a[16:10]} ^ 8'h5A;
  endfunction

  // Memory device: one-cycle read latency.
  logic [7:0] mem [int];
  always @(posedge clk_sys) begin
    if (mem_write) mem[int'(mem_address)] = mem_writedata;
    if (mem_read)
      mem_readdata <= mem.exists(int'(mem_address)) ?
                      mem[int'(mem_address)] : pat(mem_address);
  end

  typedef struct {
    logic [16:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] gold [int];
  int         waited = 0;
  int         own = 0;
  logic [7:0] exp_rd = '0;
  logic [7:0] last_h = '0;
  logic [7:0] last_d = '0;
  bit         h_seen = 0;
  bit         d_seen = 0;
  int         tests = 0;
  int         fails = 0;

  logic        s_mrd, s_mwr, s_hwait, s_dwait, s_hrv, s_drv;
  logic [16:0] s_maddr;
  logic [7:0]  s_hdata, s_ddata;

  function automatic logic [7:0] gval(input logic [16:0] a);
    return gold.exists(int'(a)) ? gold[int'(a)] : pat(a);
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: compare outputs to the model, then advance it.
  // g: 0 none, 1 display, 2 buffered write, 3 host read.
  task automatic tick();
    int g;
    bit rdq, pend, acc;
    @(negedge clk_sys);
    s_mrd = mem_read;      s_mwr = mem_write;
    s_maddr = mem_address;
    s_hwait = host_waitrequest;
    s_dwait = disp_waitrequest;
    s_hrv = host_readdatavalid;
    s_drv = disp_readdatavalid;
    s_hdata = host_readdata;
    s_ddata = disp_readdata;
    if (!rst) begin
      wq.delete();
      waited = 0;
      own = 0;
    end
    rdq  = host_read && !host_write;
    pend = (wq.size() > 0) || rdq;
    g = 0;
    if (!rst) g = 0;
    else if (pend && waited >= MAXW) g = (wq.size() > 0) ? 2 : 3;
    else if (disp_read) g = 1;
    else if (wq.size() > 0) g = 2;
    else if (rdq) g = 3;
    acc = rst && host_write && (wq.size() == 0 || g == 2);

    chk("mem_read", 32'(mem_read), 32'(g == 1 || g == 3));
    chk("mem_write", 32'(mem_write), 32'(g == 2));
    if (g == 1) chk("addr_disp", 32'(mem_address), 32'(disp_address));
    if (g == 3) chk("addr_host", 32'(mem_address), 32'(host_address));
    if (g == 2) begin
      chk("addr_wbuf", 32'(mem_address), 32'(wq[0].a));
      chk("wdata", 32'(mem_writedata), 32'(wq[0].d));
    end
    chk("disp_wait", 32'(disp_waitrequest), 32'(g != 1));
    if (!rst) chk("host_wait_rst", 32'(host_waitrequest), 1);
    else if (host_write)
      chk("host_wait_wr", 32'(host_waitrequest), 32'(!acc));
    else if (rdq)
      chk("host_wait_rd", 32'(host_waitrequest), 32'(g != 3));
    chk("host_rv", 32'(host_readdatavalid), 32'(own == 1));
    chk("disp_rv", 32'(disp_readdatavalid), 32'(own == 2));
    if (own == 1) begin
      chk("host_rdata", 32'(host_readdata), 32'(exp_rd));
      last_h = exp_rd;
      h_seen = 1;
    end else if (h_seen) begin
      chk("host_hold", 32'(host_readdata), 32'(last_h));
    end
    if (own == 2) begin
      chk("disp_rdata", 32'(disp_readdata), 32'(exp_rd));
      last_d = exp_rd;
      d_seen = 1;
    end else if (d_seen) begin
      chk("disp_hold", 32'(disp_readdata), 32'(last_d));
    end

    if (rst) begin
      own = 0;
      if (g == 1) begin own = 2; exp_rd = gval(disp_address); end
      if (g == 3) begin own = 1; exp_rd = gval(host_address); end
      if (g == 2) begin
        gold[int'(wq[0].a)] = wq[0].d;
        void'(wq.pop_front());
      end
      if (acc) wq.push_back('{a: host_address, d: host_writedata});
      if (!pend || g >= 2) waited = 0;
      else if (waited < MAXW) waited = waited + 1;
    end
    @(posedge clk_sys);
    #1;
  endtask

  typedef struct {
    logic        hw, hr;
    logic [16:0] ha;
    logic [7:0]  hd;
    logic        dr;
    logic [16:0] da;
    logic        mrd, mwr;
    logic [16:0] maddr;
    logic        hwait, dwait, hrv, drv;
    logic [7:0]  rdata;
  } vec_t;

  function automatic vec_t mk(
    input logic hw, input logic hr, input logic [16:0] ha,
    input logic [7:0] hd, input logic dr, input logic [16:0] da,
    input logic mrd, input logic mwr, input logic [16:0] maddr,
    input logic hwait, input logic dwait,
    input logic hrv, input logic drv, input logic [7:0] rdata);
    vec_t v;
    v.hw = hw; v.hr = hr; v.ha = ha; v.hd = hd;
    v.dr = dr; v.da = da; v.mrd = mrd; v.mwr = mwr;
    v.maddr = maddr; v.hwait = hwait; v.dwait = dwait;
    v.hrv = hrv; v.drv = drv; v.rdata = rdata;
    return v;
  endfunction

  vec_t vt[9];

  initial begin
    int hit, stall, acc_at, wcnt;
    logic acc_wr;
    logic [16:0] acc_addr;

    // Write 0x100 <- A5, then it drains next cycle.
    vt[0] = mk(1,0,17'h00100,8'hA5,0,0, 0,0,0, 0,1,0,0,0);
    vt[1] = mk(0,0,0,0,0,0, 0,1,17'h00100, 1,1,0,0,0);
    // Write then read same address: read waits for drain.
    vt[2] = mk(1,0,17'h00010,8'h3C,0,0, 0,0,0, 0,1,0,0,0);
    vt[3] = mk(0,1,17'h00010,0,0,0, 0,1,17'h00010, 1,1,0,0,0);
    vt[4] = mk(0,1,17'h00010,0,0,0, 1,0,17'h00010, 0,1,0,0,0);
    vt[5] = mk(0,0,0,0,0,0, 0,0,0, 1,1,1,0,8'h3C);
    // Display and host read together: display first.
    vt[6] = mk(0,1,17'h00000,0,1,17'h1FFFF,
               1,0,17'h1FFFF, 1,0,0,0,0);
    vt[7] = mk(0,1,17'h00000,0,0,0,
               1,0,17'h00000, 0,1,0,1,pat(17'h1FFFF));
    vt[8] = mk(0,0,0,0,0,0, 0,0,0, 1,1,1,0,pat(17'h00000));

    rst = 1'b0;
    tick();
    chk("rst_mem_read", 32'(s_mrd), 0);
    chk("rst_host_wait", 32'(s_hwait), 1);
    tick();
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      host_write = vt[i].hw;  host_read = vt[i].hr;
      host_address = vt[i].ha; host_writedata = vt[i].hd;
      disp_read = vt[i].dr;   disp_address = vt[i].da;
      tick();
      chk($sformatf("v%0d_mrd", i), 32'(s_mrd), 32'(vt[i].mrd));
      chk($sformatf("v%0d_mwr", i), 32'(s_mwr), 32'(vt[i].mwr));
      if (vt[i].mrd || vt[i].mwr)
        chk($sformatf("v%0d_addr", i), 32'(s_maddr), 32'(vt[i].maddr));
      chk($sformatf("v%0d_hwait", i), 32'(s_hwait), 32'(vt[i].hwait));
      chk($sformatf("v%0d_dwait", i), 32'(s_dwait), 32'(vt[i].dwait));
      chk($sformatf("v%0d_hrv", i), 32'(s_hrv), 32'(vt[i].hrv));
      chk($sformatf("v%0d_drv", i), 32'(s_drv), 32'(vt[i].drv));
      if (vt[i].hrv)
        chk($sformatf("v%0d_hdata", i), 32'(s_hdata), 32'(vt[i].rdata));
      if (vt[i].drv)
        chk($sformatf("v%0d_ddata", i), 32'(s_ddata), 32'(vt[i].rdata));
    end

    // Display held, host read starves for MAXW cycles.
    disp_read = 1; disp_address = 17'h00300;
    host_read = 1; host_address = 17'h00200; host_write = 0;
    hit = -1; stall = 0;
    for (int i = 0; i < 10 && hit < 0; i++) begin
      tick();
      if (s_mrd && s_maddr == 17'h00200) begin
        hit = i;
        stall = int'(s_dwait);
      end
    end
    chk("starve_grant_cycle", 32'(hit), 32'(MAXW));
    chk("starve_disp_stalled", 32'(stall), 1);
    host_read = 0;
    tick();
    chk("disp_resume_addr", 32'(s_maddr), 32'h00300);
    chk("disp_resume_wait", 32'(s_dwait), 0);
    chk("disp_resume_hrv", 32'(s_hrv), 1);

    // Back-to-back writes with display hogging the port.
    host_write = 1; host_address = 17'h00040; host_writedata = 8'h11;
    disp_address = 17'h00301;
    tick();
    chk("wr1_accept", 32'(s_hwait), 0);
    host_address = 17'h00041; host_writedata = 8'h22;
    acc_at = -1; acc_wr = 0; acc_addr = '0;
    for (int i = 0; i < 12 && acc_at < 0; i++) begin
      tick();
      if (!s_hwait) begin
        acc_at = i; acc_wr = s_mwr; acc_addr = s_maddr;
      end
    end
    chk("wr2_accept_cycle", 32'(acc_at), 32'(MAXW));
    chk("wr2_drain_write", 32'(acc_wr), 1);
    chk("wr2_drain_addr", 32'(acc_addr), 32'h00040);
    host_write = 0;
    for (int i = 0; i < 6; i++) tick();
    disp_read = 0;
    tick();

    // Reset discards a buffered write.
    host_write = 1; host_address = 17'h00077; host_writedata = 8'h99;
    tick();
    host_write = 0;
    rst = 0;
    tick();
    chk("rst_no_write", 32'(s_mwr), 0);
    chk("rst_hrv", 32'(s_hrv), 0);
    chk("rst_dwait", 32'(s_dwait), 1);
    rst = 1;
    wcnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      wcnt += int'(s_mwr);
    end
    chk("post_rst_writes", 32'(wcnt), 0);
    chk("post_rst_starve", 32'(dut.starve_cnt), 0);

    // Random traffic over a small address set.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) != 0);
      host_write = ($urandom_range(0, 3) == 0);
      host_read = ($urandom_range(0, 2) == 0);
      host_address = 17'($urandom_range(0, 7)) |
                     ($urandom_range(0, 1) ? 17'h1FFF0 : 17'h0);
      host_writedata = 8'($urandom);
      disp_read = ($urandom_range(0, 1) == 0);
      disp_address = 17'($urandom_range(0, 7)) |
                     ($urandom_range(0, 1) ? 17'h1FFF0 : 17'h0);
      tick();
    end
    rst = 1;
    host_write = 0; host_read = 0; disp_read = 0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
